mac_result_drain: RTL and testbench

Downstream stage of the 2x2 `mac_array`. Captures each MAC's accumulator whenever that MAC asserts its `valid_out` bit and holds it in a per-lane register. Drains the held results one per cycle through a valid/ready output port, using round-robin arbitration. Each result is requantized from ACC_W to W bits with round-half-up and saturation; the raw value is also provided.

---
 rtl/mac_result_drain.sv | 154 +++++++++++++++
 tb/tb_mac_result_drain.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_drain.sv
// Result drain for the 2x2 mac_array: per-lane capture registers, round-robin
// drain through a valid/ready port, requantization with round-half-up and saturation.
module mac_result_drain #(
   parameter int W      = 8,
   parameter int ACC_W  = 16,
   parameter int N_MACS = 4,
   parameter int SHIFT  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [ACC_W-1:0] acc_in_0,
   input  logic signed [ACC_W-1:0] acc_in_1,
   input  logic signed [ACC_W-1:0] acc_in_2,
   input  logic signed [ACC_W-1:0] acc_in_3,
   input  logic [N_MACS-1:0]       valid_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [W-1:0]     out_data,
   output logic [ACC_W-1:0]        out_raw,
   output logic [1:0]              out_idx,
   output logic                    out_sat,
   output logic                    group_done,
   output logic [N_MACS-1:0]       ovf,
   input  logic                    ovf_clr
);

   localparam logic signed [W-1:0]     Q_MAX   = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]     Q_MIN   = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [ACC_W:0]   SAT_MAX = {{(ACC_W+1-W){1'b0}}, Q_MAX};
   localparam logic signed [ACC_W:0]   SAT_MIN = {{(ACC_W+1-W){1'b1}}, Q_MIN};
   // Half an output LSB; collapses to zero when SHIFT is 0.
   localparam logic signed [ACC_W:0]   RND     = ((ACC_W+1)'(1) << SHIFT) >> 1;

   logic signed [ACC_W-1:0] w_acc [N_MACS];
   logic [ACC_W-1:0]        r_hold [N_MACS];
   logic [N_MACS-1:0]       r_full;
   logic [N_MACS-1:0]       r_ovf;
   logic [1:0]              r_rr;
   logic [1:0]              r_grp;
   logic                    r_valid;
   logic signed [W-1:0]     r_data;
   logic [ACC_W-1:0]        r_raw;
   logic [1:0]              r_idx;
   logic                    r_sat;
   logic                    r_gdone;

   logic                    w_found;
   logic [1:0]              w_grant;
   logic [1:0]              w_cand;
   logic                    w_load;
   logic                    w_xfer;
   logic [N_MACS-1:0]       w_drain;
   logic [N_MACS-1:0]       w_cap;
   logic [N_MACS-1:0]       w_ovf_set;
   logic signed [ACC_W:0]   w_t;
   logic signed [ACC_W:0]   w_r;
   logic signed [W-1:0]     w_q;
   logic                    w_qsat;

   assign w_acc[0] = acc_in_0;
   assign w_acc[1] = acc_in_1;
   assign w_acc[2] = acc_in_2;
   assign w_acc[3] = acc_in_3;

   // First full lane at or after the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_grant = r_rr;
      w_cand  = r_rr;
      for (int unsigned j = 0; j < N_MACS; j++) begin
         w_cand = r_rr + 2'(j);
         if (!w_found && r_full[w_cand]) begin
            w_found = 1'b1;
            w_grant = w_cand;
         end
      end
   end

   assign w_xfer = r_valid && out_ready;
   assign w_load = (!r_valid || out_ready) && w_found;

   // A lane being drained this cycle may accept a new strobe without overflow.
   always_comb begin
      w_drain   = '0;
      w_cap     = '0;
      w_ovf_set = '0;
      for (int unsigned i = 0; i < N_MACS; i++) begin
         w_drain[i]   = w_load && (w_grant == 2'(i));
         w_cap[i]     = valid_in[i] && (!r_full[i] || w_drain[i]);
         w_ovf_set[i] = valid_in[i] && r_full[i] && !w_drain[i];
      end
   end

   always_comb begin
      w_t    = $signed({r_hold[w_grant][ACC_W-1], r_hold[w_grant]}) + RND;
      w_r    = w_t >>> SHIFT;
      w_q    = w_r[W-1:0];
      w_qsat = 1'b0;
      if (w_r > SAT_MAX) begin
         w_q    = Q_MAX;
         w_qsat = 1'b1;
      end else if (w_r < SAT_MIN) begin
         w_q    = Q_MIN;
         w_qsat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_MACS; i++) begin
            r_hold[i] <= '0;
         end
         r_full  <= '0;
         r_ovf   <= '0;
         r_rr    <= '0;
         r_grp   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_raw   <= '0;
         r_idx   <= '0;
         r_sat   <= 1'b0;
         r_gdone <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N_MACS; i++) begin
            if (w_cap[i]) begin
               r_hold[i] <= w_acc[i];
            end
         end
         r_full <= (r_full & ~w_drain) | w_cap;
         r_ovf  <= w_ovf_set | (ovf_clr ? '0 : r_ovf);
         if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_q;
            r_raw   <= r_hold[w_grant];
            r_idx   <= w_grant;
            r_sat   <= w_qsat;
            r_rr    <= w_grant + 2'd1;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
         r_grp   <= r_grp + {1'b0, w_xfer};
         r_gdone <= w_xfer && (r_grp == 2'd3);
      end
   end

   assign out_valid  = r_valid;
   assign out_data   = r_data;
   assign out_raw    = r_raw;
   assign out_idx    = r_idx;
   assign out_sat    = r_sat;
   assign group_done = r_gdone;
   assign ovf        = r_ovf;

endmodule

// File: tb/tb_mac_result_drain.sv
// Self-checking bench for mac_result_drain: directed scenarios plus randomized
// traffic compared against a queue-free lane/arbiter reference model.
module tb_mac_result_drain;
   localparam int W      = 8;
   localparam int ACC_W  = 16;
   localparam int N      = 4;
   localparam int SHIFT  = 4;
   localparam int EXP_W  = 1 + W + ACC_W + 2 + 1 + 1 + N;

   logic                    clk = 1'b0;
   logic                    rst;
   logic signed [ACC_W-1:0] acc_in_0, acc_in_1, acc_in_2, acc_in_3;
   logic [N-1:0]            valid_in;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [W-1:0]     out_data;
   logic [ACC_W-1:0]        out_raw;
   logic [1:0]              out_idx;
   logic                    out_sat;
   logic                    group_done;
   logic [N-1:0]            ovf;
   logic                    ovf_clr;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit       m_full [N];
   int       m_hold [N];
   int       m_rr;
   bit       m_ov;
   int       m_data, m_raw, m_idx;
   bit       m_sat, m_gd;
   bit [N-1:0] m_ovf;
   int       m_cnt;

   always #5 clk = ~clk;

   mac_result_drain #(.W(W), .ACC_W(ACC_W), .N_MACS(N), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst),
      .acc_in_0(acc_in_0), .acc_in_1(acc_in_1), .acc_in_2(acc_in_2), .acc_in_3(acc_in_3),
      .valid_in(valid_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_raw(out_raw), .out_idx(out_idx), .out_sat(out_sat),
      .group_done(group_done), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   function automatic void rq(input int acc, output int q, output bit s);
      int t, r, hi, lo;
      hi = (1 << (W-1)) - 1;
      lo = -(1 << (W-1));
      t = acc + ((SHIFT > 0) ? (1 << (SHIFT-1)) : 0);
      r = t >>> SHIFT;
      s = 1'b0;
      q = r;
      if (r > hi) begin q = hi; s = 1'b1; end
      else if (r < lo) begin q = lo; s = 1'b1; end
   endfunction

   function automatic int acc_of(input int i);
      case (i)
         0: return int'(acc_in_0);
         1: return int'(acc_in_1);
         2: return int'(acc_in_2);
         default: return int'(acc_in_3);
      endcase
   endfunction

   // Advance the model by one clock using the inputs as they stand before the edge.
   task automatic model_step();
      int k;
      bit found, xfer, load;
      bit [N-1:0] newovf;
      if (rst) begin
         foreach (m_full[i]) m_full[i] = 1'b0;
         m_rr = 0; m_ov = 0; m_data = 0; m_raw = 0; m_idx = 0;
         m_sat = 0; m_gd = 0; m_ovf = '0; m_cnt = 0;
         return;
      end
      xfer  = m_ov && out_ready;
      found = 1'b0;
      k     = 0;
      for (int j = 0; j < N; j++) begin
         if (!found && m_full[(m_rr + j) % N]) begin
            found = 1'b1;
            k = (m_rr + j) % N;
         end
      end
      load = (!m_ov || out_ready) && found;
      m_gd = xfer && (m_cnt == 3);
      if (xfer) m_cnt = (m_cnt + 1) % 4;
      if (load) begin
         m_ov = 1'b1;
         rq(m_hold[k], m_data, m_sat);
         m_raw = m_hold[k];
         m_idx = k;
         m_rr = (k + 1) % N;
         m_full[k] = 1'b0;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      newovf = '0;
      for (int i = 0; i < N; i++) begin
         if (valid_in[i]) begin
            if (!m_full[i]) begin
               m_full[i] = 1'b1;
               m_hold[i] = acc_of(i);
            end else begin
               newovf[i] = 1'b1;
            end
         end
      end
      m_ovf = newovf | (ovf_clr ? '0 : m_ovf);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; valid_in = '0; out_ready = 1'b0; ovf_clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid_in = '1; out_ready = 1'b1; ovf_clr = 1'b0;
      acc_in_0 = 16'sd5; acc_in_1 = 16'sd6; acc_in_2 = 16'sd7; acc_in_3 = 16'sd8;
      tick(); tick();
      n_checks++;
      if ({out_valid, out_data, out_raw, out_idx, out_sat, group_done, ovf} !== '0) begin
         n_errors++;
         $display("FAIL reset_values: got v=%b d=%0d raw=%0d idx=%0d sat=%b gd=%b ovf=%b, want all zero",
                  out_valid, out_data, out_raw, out_idx, out_sat, group_done, ovf);
      end
      rst = 1'b0; valid_in = '0;
      tick(); tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_no_capture: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_single();
      do_reset();
      out_ready = 1'b1; acc_in_0 = 16'sd100; valid_in = 4'b0001;
      tick();
      valid_in = '0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_latency: out_valid=%b at t+1 want 0", out_valid);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'd0 || $signed(out_data) !== 6 ||
          out_raw !== 16'd100 || out_sat !== 1'b0) begin
         n_errors++;
         $display("FAIL single_result: v=%b idx=%0d d=%0d raw=%0d sat=%b want 1/0/6/100/0",
                  out_valid, out_idx, out_data, out_raw, out_sat);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL single_drop: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_requant();
      int vals [6] = '{-100, 32767, -32768, 24, 7, -9};
      int expd [6] = '{-6, 127, -128, 2, 0, -1};
      bit exps [6] = '{0, 1, 1, 0, 0, 0};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         acc_in_0 = ACC_W'(vals[i]); valid_in = 4'b0001;
         tick();
         valid_in = '0;
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || $signed(out_data) !== expd[i] || out_sat !== exps[i] ||
             $signed(out_raw) !== vals[i]) begin
            n_errors++;
            $display("FAIL requant[%0d]: acc=%0d got d=%0d sat=%b raw=%0d v=%b want d=%0d sat=%b",
                     i, vals[i], out_data, out_sat, $signed(out_raw), out_valid, expd[i], exps[i]);
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      out_ready = 1'b1;
      acc_in_0 = 16'sd16; acc_in_1 = 16'sd32; acc_in_2 = 16'sd48; acc_in_3 = 16'sd64;
      valid_in = 4'b1111;
      tick();
      valid_in = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_idx !== 2'(i) || $signed(out_data) !== i + 1 ||
             group_done !== 1'b0) begin
            n_errors++;
            $display("FAIL rr_order[%0d]: v=%b idx=%0d d=%0d gd=%b want 1/%0d/%0d/0",
                     i, out_valid, out_idx, out_data, group_done, i, i + 1);
         end
      end
      acc_in_0 = 16'sd80; acc_in_1 = 16'sd96;
      tick();
      n_checks++;
      if (group_done !== 1'b1 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rr_group_done: gd=%b v=%b want 1/0", group_done, out_valid);
      end
      valid_in = 4'b0011;
      tick();
      valid_in = '0;
      n_checks++;
      if (group_done !== 1'b0) begin
         n_errors++;
         $display("FAIL rr_gd_pulse: gd=%b want 0", group_done);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'd0 || $signed(out_data) !== 5) begin
         n_errors++;
         $display("FAIL rr_second0: v=%b idx=%0d d=%0d want 1/0/5", out_valid, out_idx, out_data);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'd1 || $signed(out_data) !== 6) begin
         n_errors++;
         $display("FAIL rr_second1: v=%b idx=%0d d=%0d want 1/1/6", out_valid, out_idx, out_data);
      end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      acc_in_2 = 16'sd10; valid_in = 4'b0100;
      tick();
      valid_in = '0;
      tick();
      acc_in_2 = 16'sd20; valid_in = 4'b0100;
      tick();
      acc_in_2 = 16'sd30;
      tick();
      valid_in = '0;
      n_checks++;
      if (ovf !== 4'b0100) begin
         n_errors++;
         $display("FAIL bp_ovf_set: ovf=%b want 0100", ovf);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_raw !== 16'd10 || out_idx !== 2'd2 || $signed(out_data) !== 1) begin
            n_errors++;
            $display("FAIL bp_stable[%0d]: v=%b raw=%0d idx=%0d d=%0d want 1/10/2/1",
                     i, out_valid, out_raw, out_idx, out_data);
         end
      end
      acc_in_2 = 16'sd40; valid_in = 4'b0100; ovf_clr = 1'b1;
      tick();
      valid_in = '0;
      n_checks++;
      if (ovf !== 4'b0100) begin
         n_errors++;
         $display("FAIL bp_ovf_priority: ovf=%b want 0100", ovf);
      end
      tick();
      ovf_clr = 1'b0;
      n_checks++;
      if (ovf !== 4'b0000) begin
         n_errors++;
         $display("FAIL bp_ovf_clr: ovf=%b want 0000", ovf);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_raw !== 16'd20 || out_idx !== 2'd2) begin
         n_errors++;
         $display("FAIL bp_release: v=%b raw=%0d idx=%0d want 1/20/2", out_valid, out_raw, out_idx);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_dropped: v=%b raw=%0d want v=0", out_valid, out_raw);
      end
   endtask

   task automatic test_free_then_fill();
      do_reset();
      out_ready = 1'b1;
      acc_in_1 = 16'sd16; valid_in = 4'b0010;
      tick();
      acc_in_1 = 16'sd48;
      tick();
      valid_in = '0;
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_raw !== 16'd16 || ovf !== 4'b0000) begin
         n_errors++;
         $display("FAIL ftf_grant: v=%b idx=%0d raw=%0d ovf=%b want 1/1/16/0000",
                  out_valid, out_idx, out_raw, ovf);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_raw !== 16'd48 || $signed(out_data) !== 3) begin
         n_errors++;
         $display("FAIL ftf_refill: v=%b idx=%0d raw=%0d d=%0d want 1/1/48/3",
                  out_valid, out_idx, out_raw, out_data);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      acc_in_0 = 16'sd1000; acc_in_1 = 16'sd2000; acc_in_2 = 16'sd3000; acc_in_3 = 16'sd4000;
      valid_in = 4'b1111;
      tick();
      valid_in = '0;
      tick();
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_precond: v=%b want 1", out_valid);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({out_valid, out_data, out_raw, out_idx, out_sat, group_done, ovf} !== '0) begin
         n_errors++;
         $display("FAIL mid_reset: v=%b d=%0d raw=%0d idx=%0d sat=%b gd=%b ovf=%b want all zero",
                  out_valid, out_data, out_raw, out_idx, out_sat, group_done, ovf);
      end
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_stale[%0d]: v=%b raw=%0d want v=0", i, out_valid, out_raw);
         end
      end
   endtask

   function automatic logic [ACC_W-1:0] rand_acc();
      case ($urandom_range(0, 5))
         0: return 16'h7fff;
         1: return 16'h8000;
         2: return ACC_W'($urandom_range(0, 255)) - ACC_W'(128);
         default: return ACC_W'($urandom);
      endcase
   endfunction

   task automatic test_random();
      logic [EXP_W-1:0] exp_v, got_v;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         acc_in_0 = rand_acc(); acc_in_1 = rand_acc();
         acc_in_2 = rand_acc(); acc_in_3 = rand_acc();
         valid_in  = N'($urandom) & N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         ovf_clr   = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 299) == 0);
         tick();
         exp_v = {m_ov, W'(m_data), ACC_W'(m_raw), 2'(m_idx), m_sat, m_gd, m_ovf};
         got_v = {out_valid, out_data, out_raw, out_idx, out_sat, group_done, ovf};
         n_checks++;
         if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL random[%0d]: got v=%b d=%0d raw=%0d idx=%0d sat=%b gd=%b ovf=%b want v=%b d=%0d raw=%0d idx=%0d sat=%b gd=%b ovf=%b",
                     c, out_valid, out_data, $signed(out_raw), out_idx, out_sat, group_done, ovf,
                     m_ov, m_data, m_raw, m_idx, m_sat, m_gd, m_ovf);
         end
      end
      rst = 1'b0; valid_in = '0; ovf_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid_in = '0; out_ready = 1'b0; ovf_clr = 1'b0;
      acc_in_0 = '0; acc_in_1 = '0; acc_in_2 = '0; acc_in_3 = '0;
      test_reset();
      test_single();
      test_requant();
      test_round_robin();
      test_backpressure();
      test_free_then_fill();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
